// File: rtl/ioctl_mem_arb_if.sv
// ioctl_mem_arb_if: groups the signals between the memory arbiter and the
// blocks around it.
//   ioctl_* : ARM->FPGA download stream (strobe, byte address, byte data)
//   cpu_*   : CPU request/acknowledge port (read/write, one-cycle ack)
//   rd_*    : image-reader read port (one-cycle ack)
//   mem_*   : external memory controller port (req held until ack)
//   dl_*    : download status (busy, sticky overflow)
// Modport slave is the arbiter's view; modport master is the view of the
// requesters plus the memory controller.
interface ioctl_mem_arb_if #(
  parameter int AW = 25
);
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_dout;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  logic          cpu_ack;

  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_dout;
  logic          rd_ack;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
  logic          mem_ack;

  logic          dl_busy;
  logic          dl_overflow;

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_ack,
    input  rd_req, rd_addr,
    output rd_dout, rd_ack,
    output mem_req, mem_we, mem_addr, mem_din,
    input  mem_dout, mem_ack,
    output dl_busy, dl_overflow
  );

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_ack,
    output rd_req, rd_addr,
    input  rd_dout, rd_ack,
    input  mem_req, mem_we, mem_addr, mem_din,
    output mem_dout, mem_ack,
    input  dl_busy, dl_overflow
  );
endinterface

// File: rtl/ioctl_mem_arb.sv
// ioctl_mem_arb: shares one external memory port between the download
// stream, the CPU and the tape/disk image reader.
// Download bytes arrive as short strobes with no back-pressure, so each one
// is captured into a small FIFO and later written to memory. Arbitration is
// fixed priority: download FIFO > CPU > reader.
// Ports:
//   clk_sys : system clock, all logic on its rising edge
//   rst_n   : synchronous active-low reset
//   bus     : ioctl_mem_arb_if.slave (download, CPU, reader, memory, status)
module ioctl_mem_arb #(
  parameter int AW        = 25,
  parameter int FIFO_LOG2 = 2
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  ioctl_mem_arb_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam int unsigned EW    = AW + 8;
  localparam logic [FIFO_LOG2:0] PTR_ONE = 1;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;
  typedef enum logic [1:0] {OWN_FIFO, OWN_CPU, OWN_RD} owner_e;

  logic                 wr_q, dl_q;
  logic [EW-1:0]        fifo_q [DEPTH];
  logic [FIFO_LOG2:0]   wptr_q, rptr_q;
  logic                 ovf_q;

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  logic                 mreq_q, mreq_d;
  logic                 mwe_q, mwe_d;
  logic [AW-1:0]        maddr_q, maddr_d;
  logic [7:0]           mdin_q, mdin_d;
  logic [7:0]           cdout_q, cdout_d;
  logic [7:0]           rdout_q, rdout_d;
  logic                 cack_q, cack_d;
  logic                 rack_q, rack_d;

  logic                 push, pop, push_ok;
  logic                 empty, full;
  logic [EW-1:0]        head;

  // One push per strobe: only the rising edge of ioctl_wr counts.
  assign push  = bus.ioctl_wr & ~wr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[FIFO_LOG2] != rptr_q[FIFO_LOG2]) &&
                 (wptr_q[FIFO_LOG2-1:0] == rptr_q[FIFO_LOG2-1:0]);
  assign pop   = (state_q == ST_BUSY) && (owner_q == OWN_FIFO) && bus.mem_ack;
  // A pop in the same cycle frees the slot, so a push while full still fits.
  assign push_ok = push && (!full || pop);
  assign head    = fifo_q[rptr_q[FIFO_LOG2-1:0]];

  // Storage needs no reset; only the pointers define its contents.
  always_ff @(posedge clk_sys) begin
    if (rst_n && push_ok) begin
      fifo_q[wptr_q[FIFO_LOG2-1:0]] <= {bus.ioctl_addr, bus.ioctl_dout};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      dl_q    <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      state_q <= ST_IDLE;
      owner_q <= OWN_FIFO;
      mreq_q  <= 1'b0;
      mwe_q   <= 1'b0;
      maddr_q <= '0;
      mdin_q  <= '0;
      cdout_q <= '0;
      rdout_q <= '0;
      cack_q  <= 1'b0;
      rack_q  <= 1'b0;
    end else begin
      wr_q <= bus.ioctl_wr;
      dl_q <= bus.ioctl_download;
      if (push_ok) wptr_q <= wptr_q + PTR_ONE;
      if (pop)     rptr_q <= rptr_q + PTR_ONE;
      if (push && full && !pop) begin
        ovf_q <= 1'b1;
      end else if (bus.ioctl_download && !dl_q) begin
        ovf_q <= 1'b0;
      end
      state_q <= state_d;
      owner_q <= owner_d;
      mreq_q  <= mreq_d;
      mwe_q   <= mwe_d;
      maddr_q <= maddr_d;
      mdin_q  <= mdin_d;
      cdout_q <= cdout_d;
      rdout_q <= rdout_d;
      cack_q  <= cack_d;
      rack_q  <= rack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    mreq_d  = mreq_q;
    mwe_d   = mwe_q;
    maddr_d = maddr_q;
    mdin_d  = mdin_q;
    cdout_d = cdout_q;
    rdout_d = rdout_q;
    cack_d  = 1'b0;
    rack_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          owner_d           = OWN_FIFO;
          mwe_d             = 1'b1;
          {maddr_d, mdin_d} = head;
          mreq_d            = 1'b1;
          state_d           = ST_BUSY;
        end else if (bus.cpu_req) begin
          owner_d = OWN_CPU;
          mwe_d   = bus.cpu_we;
          maddr_d = bus.cpu_addr;
          mdin_d  = bus.cpu_din;
          mreq_d  = 1'b1;
          state_d = ST_BUSY;
        end else if (bus.rd_req) begin
          owner_d = OWN_RD;
          mwe_d   = 1'b0;
          maddr_d = bus.rd_addr;
          mdin_d  = '0;
          mreq_d  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.mem_ack) begin
          mreq_d  = 1'b0;
          state_d = ST_IDLE;
          case (owner_q)
            OWN_CPU: begin
              if (!mwe_q) cdout_d = bus.mem_dout;
              cack_d = 1'b1;
            end
            OWN_RD: begin
              rdout_d = bus.mem_dout;
              rack_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.mem_req     = mreq_q;
  assign bus.mem_we      = mwe_q;
  assign bus.mem_addr    = maddr_q;
  assign bus.mem_din     = mdin_q;
  assign bus.cpu_dout    = cdout_q;
  assign bus.cpu_ack     = cack_q;
  assign bus.rd_dout     = rdout_q;
  assign bus.rd_ack      = rack_q;
  assign bus.dl_overflow = ovf_q;
  // Busy until the last captured byte has actually been written.
  assign bus.dl_busy     = bus.ioctl_download | ~empty |
                           ((state_q == ST_BUSY) && (owner_q == OWN_FIFO));

endmodule

// File: tb/tb_ioctl_mem_arb.sv
`timescale 1ns/1ps
module tb_ioctl_mem_arb;
  localparam int AW    = 25;
  localparam int DEPTH = 4;

  logic clk_sys = 1'b0;
  logic rst_n;
  always #5 clk_sys = ~clk_sys;

  ioctl_mem_arb_if #(.AW(AW)) bus ();

  ioctl_mem_arb #(.AW(AW), .FIFO_LOG2(2)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  typedef struct { bit we; logic [AW-1:0] addr; logic [7:0] data; } txn_t;
  txn_t        log_q[$];
  logic [7:0]  mm_resp [logic [AW-1:0]];
  int          lat_cnt = 0;
  int          ack_req_n = 0;
  int          ack_done_n = 0;
  bit          hold_ack = 0;
  logic [7:0]  r_data;
  txn_t        r_txn;

  always @(posedge clk_sys) begin
    #3;
    if (!rst_n) begin
      bus.mem_ack = 1'b0;
      lat_cnt = 0;
    end else if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
      lat_cnt = 0;
    end else if (bus.mem_req) begin
      lat_cnt++;
      if ((!hold_ack && lat_cnt >= 3) || (ack_done_n < ack_req_n)) begin
        if (ack_done_n < ack_req_n) ack_done_n++;
        if (bus.mem_we) begin
          r_data = bus.mem_din;
          mm_resp[bus.mem_addr] = r_data;
        end else begin
          r_data = mm_resp.exists(bus.mem_addr) ? mm_resp[bus.mem_addr] : 8'h00;
          bus.mem_dout = r_data;
        end
        bus.mem_ack = 1'b1;
        r_txn.we = bus.mem_we; r_txn.addr = bus.mem_addr; r_txn.data = r_data;
        log_q.push_back(r_txn);
      end
    end
  end

  // ---------------- behavioural model ----------------
  typedef enum int {S_FIFO, S_CPU, S_RD} src_e;
  typedef struct { logic [AW-1:0] addr; logic [7:0] data; } ent_t;
  ent_t          fq[$];
  ent_t          m_ent;
  logic [7:0]    mm_model [logic [AW-1:0]];
  bit            m_busy, m_we, m_ovf, m_cack, m_rack, m_wr_prev, m_dl_prev;
  bit            m_pop, m_drop;
  src_e          m_src;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_din, m_cdout, m_rdout;
  bit            chk_en = 0;

  function automatic logic [7:0] mm_rd(input logic [AW-1:0] a);
    return mm_model.exists(a) ? mm_model[a] : 8'h00;
  endfunction

  always @(posedge clk_sys) begin
    if (!rst_n) begin
      fq.delete();
      m_busy = 0; m_we = 0; m_ovf = 0; m_cack = 0; m_rack = 0;
      m_wr_prev = 0; m_dl_prev = 0; m_cdout = 8'h00; m_rdout = 8'h00;
      chk_en = 1;
    end else begin
      m_pop = 0; m_drop = 0; m_cack = 0; m_rack = 0;
      if (m_busy) begin
        if (bus.mem_ack) begin
          m_busy = 0;
          case (m_src)
            S_FIFO: begin m_pop = 1; mm_model[m_addr] = m_din; end
            S_CPU: begin
              if (m_we) mm_model[m_addr] = m_din;
              else m_cdout = mm_rd(m_addr);
              m_cack = 1;
            end
            default: begin m_rdout = mm_rd(m_addr); m_rack = 1; end
          endcase
        end
      end else if (fq.size() > 0) begin
        m_busy = 1; m_src = S_FIFO; m_we = 1; m_addr = fq[0].addr; m_din = fq[0].data;
      end else if (bus.cpu_req) begin
        m_busy = 1; m_src = S_CPU; m_we = bus.cpu_we; m_addr = bus.cpu_addr; m_din = bus.cpu_din;
      end else if (bus.rd_req) begin
        m_busy = 1; m_src = S_RD; m_we = 0; m_addr = bus.rd_addr; m_din = 8'h00;
      end
      if (m_pop) void'(fq.pop_front());
      if (bus.ioctl_wr && !m_wr_prev) begin
        if (fq.size() < DEPTH) begin
          m_ent.addr = bus.ioctl_addr; m_ent.data = bus.ioctl_dout;
          fq.push_back(m_ent);
        end else begin
          m_drop = 1; m_ovf = 1;
        end
      end
      if (bus.ioctl_download && !m_dl_prev && !m_drop) m_ovf = 0;
      m_wr_prev = bus.ioctl_wr;
      m_dl_prev = bus.ioctl_download;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_sys) begin
    if (chk_en) begin
      chk("mem_req", 64'(bus.mem_req), 64'(m_busy));
      if (m_busy) begin
        chk("mem_we", 64'(bus.mem_we), 64'(m_we));
        chk("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
        if (m_we) chk("mem_din", 64'(bus.mem_din), 64'(m_din));
      end
      chk("cpu_ack", 64'(bus.cpu_ack), 64'(m_cack));
      chk("rd_ack", 64'(bus.rd_ack), 64'(m_rack));
      chk("cpu_dout", 64'(bus.cpu_dout), 64'(m_cdout));
      chk("rd_dout", 64'(bus.rd_dout), 64'(m_rdout));
      chk("dl_overflow", 64'(bus.dl_overflow), 64'(m_ovf));
      chk("dl_busy", 64'(bus.dl_busy),
          64'(bus.ioctl_download | (fq.size() != 0) | (m_busy && m_src == S_FIFO)));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #2;
  endtask

  task automatic strobe(input logic [AW-1:0] a, input logic [7:0] d);
    bus.ioctl_addr = a; bus.ioctl_dout = d; bus.ioctl_wr = 1'b1;
    step(2);
    bus.ioctl_wr = 1'b0;
    step(2);
  endtask

  task automatic wait_log(input int n, input int budget, input string nm);
    int k = 0;
    while (log_q.size() < n && k < budget) begin step(1); k++; end
    chk(nm, 64'(log_q.size()), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  int base, n_cack, n_rack, k;

  initial begin
    rst_n = 1'b0;
    bus.ioctl_download = 0; bus.ioctl_wr = 0; bus.ioctl_addr = '0; bus.ioctl_dout = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.rd_req = 0; bus.rd_addr = '0;
    bus.mem_ack = 0; bus.mem_dout = '0;
    mm_resp[25'h000100] = 8'h3C;  mm_model[25'h000100] = 8'h3C;
    mm_resp[25'h400000] = 8'h5A;  mm_model[25'h400000] = 8'h5A;

    // reset then idle
    step(3);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_cpu_ack", 64'(bus.cpu_ack), 64'd0);
    chk("rst_rd_ack", 64'(bus.rd_ack), 64'd0);
    chk("rst_cpu_dout", 64'(bus.cpu_dout), 64'd0);
    chk("rst_dl_busy", 64'(bus.dl_busy), 64'd0);
    chk("rst_dl_overflow", 64'(bus.dl_overflow), 64'd0);
    rst_n = 1'b1;
    step(20);
    chk("idle_no_access", 64'(log_q.size()), 64'd0);

    // single download byte
    bus.ioctl_download = 1; step(1);
    strobe(25'h200000, 8'hA5);
    wait_log(1, 40, "dl1_count");
    step(1);
    chk("dl1_busy_hold", 64'(bus.dl_busy), 64'd1);
    bus.ioctl_download = 0;
    k = 0;
    while (bus.dl_busy && k < 20) begin step(1); k++; end
    chk("dl1_busy_fall", 64'(bus.dl_busy), 64'd0);
    chk("dl1_we", 64'(log_q[0].we), 64'd1);
    chk("dl1_addr", 64'(log_q[0].addr), 64'h200000);
    chk("dl1_data", 64'(log_q[0].data), 64'hA5);
    step(10);
    chk("dl1_single", 64'(log_q.size()), 64'd1);

    // priority: FIFO > CPU > reader
    base = log_q.size();
    bus.ioctl_download = 1;
    bus.ioctl_addr = 25'h200001; bus.ioctl_dout = 8'h77; bus.ioctl_wr = 1;
    step(1);
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 25'h000100;
    bus.rd_req = 1; bus.rd_addr = 25'h400000;
    step(1);
    bus.ioctl_wr = 0;
    n_cack = 0; n_rack = 0;
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (bus.cpu_ack) begin bus.cpu_req = 0; n_cack++; end
      if (bus.rd_ack) begin bus.rd_req = 0; n_rack++; end
      if (!bus.cpu_req && !bus.rd_req && log_q.size() >= base + 3) break;
    end
    chk("prio_count", 64'(log_q.size()), 64'(base + 3));
    if (log_q.size() >= base + 3) begin
      chk("prio_1st_addr", 64'(log_q[base].addr), 64'h200001);
      chk("prio_1st_we", 64'(log_q[base].we), 64'd1);
      chk("prio_2nd_addr", 64'(log_q[base+1].addr), 64'h000100);
      chk("prio_2nd_we", 64'(log_q[base+1].we), 64'd0);
      chk("prio_3rd_addr", 64'(log_q[base+2].addr), 64'h400000);
    end
    chk("prio_cpu_dout", 64'(bus.cpu_dout), 64'h3C);
    chk("prio_rd_dout", 64'(bus.rd_dout), 64'h5A);
    chk("prio_cpu_acks", 64'(n_cack), 64'd1);
    chk("prio_rd_acks", 64'(n_rack), 64'd1);

    // overflow with mem_ack withheld
    bus.ioctl_download = 0; step(1);
    hold_ack = 1; bus.ioctl_download = 1; step(1);
    base = log_q.size();
    for (int i = 1; i <= 5; i++) strobe(25'h300000 + 25'(i), 8'(i));
    chk("ovf_set", 64'(bus.dl_overflow), 64'd1);
    chk("ovf_no_write", 64'(log_q.size()), 64'(base));
    hold_ack = 0;
    wait_log(base + 4, 60, "ovf_drain_count");
    step(10);
    chk("ovf_dropped", 64'(log_q.size()), 64'(base + 4));
    for (int i = 0; i < 4; i++)
      if (log_q.size() > base + i) chk("ovf_order", 64'(log_q[base+i].data), 64'(i + 1));
    bus.ioctl_download = 0; step(2);
    chk("ovf_sticky", 64'(bus.dl_overflow), 64'd1);
    bus.ioctl_download = 1; step(1);
    chk("ovf_clear", 64'(bus.dl_overflow), 64'd0);

    // full FIFO, strobe edge coincides with the pop
    hold_ack = 1;
    base = log_q.size();
    for (int i = 0; i < 4; i++) strobe(25'h310000 + 25'(i), 8'h11 + 8'(i));
    ack_req_n++;
    bus.ioctl_addr = 25'h310004; bus.ioctl_dout = 8'h15; bus.ioctl_wr = 1;
    step(2);
    bus.ioctl_wr = 0;
    step(2);
    chk("fullpop_no_ovf", 64'(bus.dl_overflow), 64'd0);
    hold_ack = 0;
    wait_log(base + 5, 80, "fullpop_count");
    for (int i = 0; i < 5; i++)
      if (log_q.size() > base + i) chk("fullpop_order", 64'(log_q[base+i].data), 64'(8'h11 + 8'(i)));
    if (log_q.size() >= base + 5) chk("fullpop_last_addr", 64'(log_q[base+4].addr), 64'h310004);

    // reset during a CPU write
    bus.ioctl_download = 0; hold_ack = 1;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 25'h000200; bus.cpu_din = 8'h99;
    k = 0;
    while (!bus.mem_req && k < 20) begin step(1); k++; end
    chk("rstmid_granted_addr", 64'(bus.mem_addr), 64'h000200);
    strobe(25'h320000, 8'h66);
    chk("rstmid_fifo_pending", 64'(bus.dl_busy), 64'd1);
    base = log_q.size();
    rst_n = 1'b0; bus.cpu_req = 0;
    step(1);
    chk("rstmid_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rstmid_cpu_ack", 64'(bus.cpu_ack), 64'd0);
    chk("rstmid_dl_busy", 64'(bus.dl_busy), 64'd0);
    rst_n = 1'b1; hold_ack = 0;
    n_cack = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.cpu_ack) n_cack++;
    end
    chk("rstmid_no_ack", 64'(n_cack), 64'd0);
    chk("rstmid_no_write", 64'(log_q.size()), 64'(base));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
